ip_stack_unit: RTL and testbench

Parametrised instruction-pointer unit. Successor to the plain increment/load IP register. Adds:
- variable-length increment
- relative branch
- CALL/RET with an internal return-address stack (RAS)
- full/empty status and a sticky fault for stack misuse

Sits between decode and fetch. `data_out` drives the fetch address bus.

---
 rtl/ip_stack_unit.sv | 112 +++++++++++
 tb/tb_ip_stack_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ip_stack_unit.sv
// Instruction-pointer unit with return-address stack.
// Drives the fetch address; handles INC, LOAD, REL, CALL and RET.
module ip_stack_unit #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned STEP_W = 3,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int unsigned SP_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [STEP_W-1:0] step,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] data_out,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC  = 3'b001,
    OP_LOAD = 3'b010,
    OP_REL  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } op_e;

  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] ras_q [DEPTH];

  logic              push_en;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] seq_ip;
  logic              full;
  logic              empty;

  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  assign seq_ip   = ip_q + ADDR_W'(step);
  // sp < DEPTH whenever a push is allowed, so the low bits index the slot.
  assign push_idx = PTR_W'(sp_q);
  assign top_idx  = PTR_W'(sp_q - SP_W'(1));

  // Next IP / stack pointer / fault; a set fault freezes everything.
  always_comb begin
    ip_d    = ip_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    push_en = 1'b0;
    if (!fault_q) begin
      unique case (op)
        OP_INC:  ip_d = seq_ip;
        OP_LOAD: ip_d = data_in;
        OP_REL:  ip_d = seq_ip + data_in;
        OP_CALL: begin
          if (full) begin
            fault_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            ip_d    = data_in;
          end
        end
        OP_RET: begin
          if (empty) begin
            fault_d = 1'b1;
          end else begin
            sp_d = sp_q - SP_W'(1);
            ip_d = ras_q[top_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ip_q    <= RESET_VEC;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  // Stack storage; contents are meaningless once sp drops past them.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      ras_q[push_idx] <= seq_ip;
    end
  end

  assign data_out    = ip_q;
  assign sp          = sp_q;
  assign fault       = fault_q;
  assign stack_full  = full;
  assign stack_empty = empty;

endmodule

// File: tb/tb_ip_stack_unit.sv
// Directed bench for ip_stack_unit.
// Hand-computed expectations, checked by immediate assertions.
module tb_ip_stack_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [2:0]  step = 3'd0;
  logic [19:0] data_in = '0;
  logic [19:0] data_out;
  logic [3:0]  sp;
  logic        stack_full;
  logic        stack_empty;
  logic        fault;

  int total = 0;
  int bad = 0;

  ip_stack_unit #(
    .ADDR_W(20), .DEPTH(8), .STEP_W(3), .RESET_VEC(20'h0)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .step(step),
    .data_in(data_in), .data_out(data_out), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [2:0] o, input logic [2:0] s,
                     input logic [19:0] d);
    op = o;
    step = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [19:0] ip,
                           input logic [3:0] s, input logic f);
    chk({tag, ".ip"}, 32'(data_out), 32'(ip));
    chk({tag, ".sp"}, 32'(sp), 32'(s));
    chk({tag, ".fault"}, 32'(fault), 32'(f));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(s == 4'd0));
    chk({tag, ".full"}, 32'(stack_full), 32'(s == 4'd8));
  endtask

  initial begin
    // 1: reset and increments
    reset = 1'b0;
    cyc(3'b001, 3'd1, 20'h0);
    chk_state("reset", 20'h0, 4'd0, 1'b0);
    reset = 1'b1;
    cyc(3'b001, 3'd1, 20'h0);
    chk("inc1", 32'(data_out), 32'h1);
    cyc(3'b001, 3'd1, 20'h0);
    chk("inc2", 32'(data_out), 32'h2);
    cyc(3'b001, 3'd1, 20'h0);
    chk("inc3", 32'(data_out), 32'h3);
    cyc(3'b001, 3'd5, 20'h0);
    chk_state("inc5", 20'h8, 4'd0, 1'b0);
    cyc(3'b001, 3'd0, 20'h0);
    chk("inc0", 32'(data_out), 32'h8);
    cyc(3'b000, 3'd7, 20'h12345);
    chk("hold", 32'(data_out), 32'h8);

    // 2: wrap and relative branch
    cyc(3'b010, 3'd0, 20'hFFFFE);
    chk("load", 32'(data_out), 32'hFFFFE);
    cyc(3'b001, 3'd3, 20'h0);
    chk("wrap", 32'(data_out), 32'h00001);
    cyc(3'b010, 3'd0, 20'h00100);
    cyc(3'b011, 3'd2, 20'hFFFF0);
    chk("rel_neg", 32'(data_out), 32'h000F2);
    cyc(3'b011, 3'd1, 20'h00010);
    chk("rel_pos", 32'(data_out), 32'h00103);

    // 3: nested CALL/RET
    cyc(3'b010, 3'd0, 20'h00010);
    cyc(3'b100, 3'd3, 20'h00400);
    chk_state("call1", 20'h00400, 4'd1, 1'b0);
    cyc(3'b001, 3'd2, 20'h0);
    cyc(3'b100, 3'd3, 20'h00800);
    chk_state("call2", 20'h00800, 4'd2, 1'b0);
    cyc(3'b101, 3'd0, 20'h0);
    chk_state("ret1", 20'h00405, 4'd1, 1'b0);
    cyc(3'b101, 3'd0, 20'h0);
    chk_state("ret2", 20'h00013, 4'd0, 1'b0);

    // 4: overflow, fault freeze, reset recovery
    for (int i = 1; i <= 8; i++) begin
      cyc(3'b100, 3'd1, 20'(32'h1000 * i));
    end
    chk_state("fill", 20'h08000, 4'd8, 1'b0);
    cyc(3'b100, 3'd1, 20'h09000);
    chk_state("ovf", 20'h08000, 4'd8, 1'b1);
    cyc(3'b001, 3'd1, 20'h0);
    chk("ovf_inc", 32'(data_out), 32'h08000);
    cyc(3'b010, 3'd0, 20'h00555);
    chk("ovf_load", 32'(data_out), 32'h08000);
    cyc(3'b101, 3'd0, 20'h0);
    chk_state("ovf_ret", 20'h08000, 4'd8, 1'b1);
    reset = 1'b0;
    cyc(3'b000, 3'd0, 20'h0);
    reset = 1'b1;
    chk_state("ovf_rst", 20'h0, 4'd0, 1'b0);

    // 5: underflow
    cyc(3'b101, 3'd0, 20'h0);
    chk_state("unf", 20'h0, 4'd0, 1'b1);
    reset = 1'b0;
    cyc(3'b000, 3'd0, 20'h0);
    reset = 1'b1;
    chk_state("unf_rst", 20'h0, 4'd0, 1'b0);

    // 6: reserved ops and reset mid-stack
    cyc(3'b010, 3'd0, 20'h00123);
    cyc(3'b111, 3'd5, 20'h00999);
    chk_state("rsv7", 20'h00123, 4'd0, 1'b0);
    cyc(3'b110, 3'd5, 20'h00999);
    chk_state("rsv6", 20'h00123, 4'd0, 1'b0);
    cyc(3'b100, 3'd1, 20'h00200);
    cyc(3'b100, 3'd1, 20'h00300);
    cyc(3'b100, 3'd1, 20'h00400);
    chk_state("sp3", 20'h00400, 4'd3, 1'b0);
    reset = 1'b0;
    cyc(3'b100, 3'd1, 20'h00500);
    reset = 1'b1;
    chk_state("rst_call", 20'h0, 4'd0, 1'b0);
    cyc(3'b101, 3'd0, 20'h0);
    chk_state("rst_disc", 20'h0, 4'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
